// File: rtl/read_burst_engine_if.sv
// Bundle of register-bank inputs, burst request and read-beat stream for read_burst_engine.
// Latency: none. This is wiring only.
// Backpressure: rd_ready from the consumer stalls the held beat on rd_valid/rd_addr/rd_data.
interface read_burst_engine_if #(
  parameter int DATA_WIDTH = 32
);
  logic [8*DATA_WIDTH-1:0] from_reg;
  logic                    we;
  logic [2:0]              wAddr;
  logic [DATA_WIDTH-1:0]   wData;
  logic                    start;
  logic [2:0]              base_addr;
  logic [3:0]              len;
  logic                    busy;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [2:0]              rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    done;

  // Engine side
  modport slave (
    input  from_reg, we, wAddr, wData, start, base_addr, len, rd_ready,
    output busy, rd_valid, rd_addr, rd_data, done
  );

  // Requester / consumer side
  modport master (
    output from_reg, we, wAddr, wData, start, base_addr, len, rd_ready,
    input  busy, rd_valid, rd_addr, rd_data, done
  );
endinterface

// File: rtl/read_burst_engine.sv
// Streams a burst of register-file values (start address + length, wrapping mod 8) as valid/ready beats.
// Latency: first beat valid 1 cycle after start, then 1 beat/cycle; done pulses 1 cycle after the last handshake.
// Backpressure: rd_ready=0 holds the current beat and freezes ptr/remaining; rd_valid only drops on a handshake.
module read_burst_engine #(
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  read_burst_engine_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [2:0]            rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [2:0]            ptr_q, ptr_d;
  logic [3:0]            remaining_q, remaining_d;
  logic                  done_q, done_d;

  logic [2:0]            load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  // Value a beat would capture this cycle: same-cycle write data wins over the bank contents.
  always_comb begin
    load_addr = (state_q == IDLE) ? bus.base_addr : ptr_q;
    if (BYPASS_EN && bus.we && (bus.wAddr == load_addr)) begin
      load_data = bus.wData;
    end else begin
      load_data = bus.from_reg[32'(load_addr) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state: start a burst, refill the beat register on each free slot, close out after the last handshake.
  always_comb begin
    state_d     = state_q;
    rd_valid_d  = rd_valid_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != 4'd0) begin
            rd_data_d   = load_data;
            rd_addr_d   = load_addr;
            rd_valid_d  = 1'b1;
            ptr_d       = bus.base_addr + 3'd1;
            remaining_d = bus.len - 4'd1;
            state_d     = READ;
          end else begin
            // Zero-length burst completes immediately without producing a beat.
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (!rd_valid_q || bus.rd_ready) begin
          if (remaining_q != 4'd0) begin
            rd_data_d   = load_data;
            rd_addr_d   = load_addr;
            rd_valid_d  = 1'b1;
            ptr_d       = ptr_q + 3'd1;
            remaining_d = remaining_q - 4'd1;
          end else if (rd_valid_q) begin
            rd_valid_d = 1'b0;
            state_d    = IDLE;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset also aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= 3'd0;
      rd_data_q   <= '0;
      ptr_q       <= 3'd0;
      remaining_q <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy     = (state_q == READ);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_read_burst_engine.sv
// Self-checking bench for read_burst_engine: directed vector table, hand-written reset sequences, random run vs model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: rd_ready driven from the table or randomly.
module tb_read_burst_engine;

  localparam int DW  = 32;
  localparam bit BYP = 1'b1;

  logic clk;
  logic reset_n;

  read_burst_engine_if #(.DATA_WIDTH(DW)) bus ();

  read_burst_engine #(.DATA_WIDTH(DW), .BYPASS_EN(BYP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        start;
    logic [2:0]  base;
    logic [3:0]  len;
    logic        rdy;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        ev;    // expected rd_valid
    logic        eb;    // expected busy
    logic        ed;    // expected done
    logic [2:0]  ea;    // expected rd_addr (checked when ev)
    logic [31:0] edat;  // expected rd_data (checked when ev)
  } vec_t;

  vec_t tbl[18];

  // ---------------- behavioural reference model ----------------
  logic        m_busy, m_valid, m_done;
  logic [2:0]  m_addr, m_base;
  logic [31:0] m_data;
  int          m_len, m_k;

  function automatic logic [31:0] rv(input logic [2:0] a);
    if (BYP && bus.we && (bus.wAddr == a)) return bus.wData;
    return bus.from_reg[a*32 +: 32];
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic hs;
    logic nd;
    if (!reset_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_addr = 0; m_data = 0; m_k = 0; m_len = 0;
      return;
    end
    hs = m_valid && bus.rd_ready;
    nd = 1'b0;
    if (!m_busy) begin
      if (bus.start) begin
        if (bus.len == 4'd0) nd = 1'b1;
        else begin
          m_base  = bus.base_addr;
          m_len   = int'(bus.len);
          m_k     = 0;
          m_addr  = bus.base_addr;
          m_data  = rv(bus.base_addr);
          m_valid = 1'b1;
          m_busy  = 1'b1;
        end
      end
    end else if (hs) begin
      m_k++;
      if (m_k == m_len) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
        nd      = 1'b1;
      end else begin
        m_addr = 3'((int'(m_base) + m_k) % 8);
        m_data = rv(m_addr);
      end
    end
    m_done = nd;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("rnd_valid", bus.rd_valid, m_valid);
    chk("rnd_busy", bus.busy, m_busy);
    chk("rnd_done", bus.done, m_done);
    if (m_valid) begin
      chk("rnd_addr", bus.rd_addr, m_addr);
      chk("rnd_data", bus.rd_data, m_data);
    end
  endtask

  task automatic edge_only();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.base_addr = 0; bus.len = 0;
    bus.we = 0; bus.wAddr = 0; bus.wData = 0; bus.rd_ready = 0;
  endtask

  initial begin
    //            st base len rdy we wa wd            ev eb ed ea  edat
    tbl[0]  = '{1, 2, 3,  1,  0, 0, 32'h0,        1, 1, 0, 2, 32'h102};
    tbl[1]  = '{0, 0, 0,  1,  1, 4, 32'h1234,     1, 1, 0, 3, 32'h103};
    tbl[2]  = '{0, 0, 0,  1,  0, 0, 32'h0,        1, 1, 0, 4, 32'h104};
    tbl[3]  = '{0, 0, 0,  1,  0, 0, 32'h0,        0, 0, 1, 0, 32'h0};
    tbl[4]  = '{1, 5, 1,  0,  1, 5, 32'hDEAD,     1, 1, 0, 5, BYP ? 32'hDEAD : 32'h105};
    tbl[5]  = '{0, 0, 0,  0,  1, 5, 32'hBEEF,     1, 1, 0, 5, BYP ? 32'hDEAD : 32'h105};
    tbl[6]  = '{0, 0, 0,  1,  0, 0, 32'h0,        0, 0, 1, 0, 32'h0};
    tbl[7]  = '{1, 3, 0,  1,  0, 0, 32'h0,        0, 0, 1, 0, 32'h0};
    tbl[8]  = '{0, 0, 0,  1,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0};
    tbl[9]  = '{1, 6, 4,  1,  0, 0, 32'h0,        1, 1, 0, 6, 32'h106};
    tbl[10] = '{1, 0, 2,  0,  0, 0, 32'h0,        1, 1, 0, 6, 32'h106};
    tbl[11] = '{0, 0, 0,  0,  0, 0, 32'h0,        1, 1, 0, 6, 32'h106};
    tbl[12] = '{0, 0, 0,  1,  1, 7, 32'hCAFE,     1, 1, 0, 7, BYP ? 32'hCAFE : 32'h107};
    tbl[13] = '{0, 0, 0,  1,  0, 0, 32'h0,        1, 1, 0, 0, 32'h100};
    tbl[14] = '{0, 0, 0,  0,  0, 0, 32'h0,        1, 1, 0, 0, 32'h100};
    tbl[15] = '{0, 0, 0,  1,  0, 0, 32'h0,        1, 1, 0, 1, 32'h101};
    tbl[16] = '{0, 0, 0,  1,  0, 0, 32'h0,        0, 0, 1, 0, 32'h0};
    tbl[17] = '{0, 0, 0,  1,  0, 0, 32'h0,        0, 0, 0, 0, 32'h0};

    for (int k = 0; k < 8; k++) bus.from_reg[k*32 +: 32] = 32'h100 + k;
    idle_inputs();

    // Reset held two cycles with a pending start request.
    reset_n = 0;
    bus.start = 1; bus.base_addr = 2; bus.len = 3; bus.rd_ready = 1;
    edge_only();
    edge_only();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.rd_valid, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_data", bus.rd_data, 32'h0);
    chk("rst_addr", bus.rd_addr, 3'h0);
    idle_inputs();
    reset_n = 1;
    edge_only();
    chk("post_rst_valid", bus.rd_valid, 1'b0);

    // Directed vectors.
    for (int i = 0; i < 18; i++) begin
      bus.start = tbl[i].start; bus.base_addr = tbl[i].base; bus.len = tbl[i].len;
      bus.rd_ready = tbl[i].rdy; bus.we = tbl[i].we; bus.wAddr = tbl[i].wa; bus.wData = tbl[i].wd;
      edge_only();
      chk($sformatf("tbl%0d_valid", i), bus.rd_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].eb);
      chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].ed);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_addr", i), bus.rd_addr, tbl[i].ea);
        chk($sformatf("tbl%0d_data", i), bus.rd_data, tbl[i].edat);
      end
    end
    idle_inputs();

    // Reset in the middle of a burst, then a normal burst afterwards.
    bus.start = 1; bus.base_addr = 1; bus.len = 5; bus.rd_ready = 0;
    edge_only();
    chk("mid_beat1_valid", bus.rd_valid, 1'b1);
    chk("mid_beat1_data", bus.rd_data, 32'h101);
    bus.start = 0; bus.rd_ready = 1;
    reset_n = 0;
    edge_only();
    chk("mid_rst_valid", bus.rd_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    reset_n = 1;
    edge_only();
    chk("mid_after_done", bus.done, 1'b0);
    chk("mid_after_valid", bus.rd_valid, 1'b0);
    bus.start = 1; bus.base_addr = 3; bus.len = 2;
    edge_only();
    chk("restart_b0_addr", bus.rd_addr, 3'd3);
    chk("restart_b0_data", bus.rd_data, 32'h103);
    bus.start = 0;
    edge_only();
    chk("restart_b1_addr", bus.rd_addr, 3'd4);
    chk("restart_b1_data", bus.rd_data, 32'h104);
    edge_only();
    chk("restart_valid_end", bus.rd_valid, 1'b0);
    chk("restart_done", bus.done, 1'b1);
    edge_only();
    chk("restart_done_clear", bus.done, 1'b0);

    // Randomized run against the model, starting from a fresh reset.
    idle_inputs();
    reset_n = 0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 3) == 0) bus.from_reg[k*32 +: 32] = $urandom;
      bus.we        = ($urandom_range(0, 2) == 0);
      bus.wAddr     = 3'($urandom_range(0, 7));
      bus.wData     = $urandom;
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.base_addr = 3'($urandom_range(0, 7));
      bus.len       = 4'($urandom_range(0, 15));
      bus.rd_ready  = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
